// File: rtl/comparador_pkg.sv
// comparador_pkg: shared state type and sweep-size helpers for the comparator stimulus engine
package comparador_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;
  function automatic int n_vec(input int w);
    return 1 << (2 * w);
  endfunction
  function automatic int idx_max(input int w);
    return n_vec(w) - 1;
  endfunction
endpackage

// File: rtl/estimulo_comparador_contador_hold.sv
// contador_hold: HOLD-cycle prescaler with synchronous clear and enable, ticking on its terminal count
module contador_hold #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(HOLD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/estimulo_comparador.sv
// estimulo_comparador: sweeps every {A,B} pair into an equality comparator and tallies wrong results
module estimulo_comparador
  import comparador_pkg::*;
#(
  parameter int W    = 2,
  parameter int HOLD = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           x_in,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic           fail_valid,
  output logic [2*W-1:0] first_fail
);
  localparam logic [2*W-1:0] IMAX = (2*W)'(idx_max(W));
  estado_t state, state_nx;
  logic [2*W-1:0] idx;
  logic tick, go, last, miss;
  // idx is parked at 0 outside RUN, so the operand outputs are plain register taps
  assign {a_out, b_out} = idx;
  assign go   = start && state != RUN;
  assign last = idx == IMAX;
  assign miss = x_in != (a_out == b_out);
  contador_hold #(.HOLD(HOLD)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (state == RUN),
    .tick (tick)
  );
  always_comb
    state_nx = go ? RUN : (tick && last) ? DONE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == RUN;
      done  <= state_nx == DONE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (go) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (tick) begin
      idx <= last ? '0 : idx + 1'b1;
      if (miss) begin
        err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          first_fail <= idx;
        end
      end
      // the final sample's own mismatch must count toward the verdict
      if (last) pass <= !miss && err_count == '0;
    end
endmodule
